// File: rtl/relu_writeback_x16.sv
// relu_writeback_x16: per-column result FIFOs, round-robin drain, optional ReLU, single buffer write port
// Ports: clk/rst (async, active-high); start_i pulse latches col_en_i and restarts a layer;
// conv_valid_i/conv_last_i/conv_result_i/addr_i per-column result stream (no backpressure);
// wr_valid_o/wr_ready_i/wr_addr_o/wr_data_o buffer write port; done_o layer complete;
// overflow_o sticky per-column FIFO overflow. Define RELU_EN to clamp negatives to 0.
module relu_writeback_x16 #(
  parameter int N_COL      = 16,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [N_COL-1:0]                      col_en_i,
  input  logic [N_COL-1:0]                      conv_valid_i,
  input  logic [N_COL-1:0]                      conv_last_i,
  input  logic [N_COL-1:0][DATA_W-1:0]          conv_result_i,
  input  logic [N_COL-1:0][ADDR_W-1:0]          addr_i,
  output logic                                  wr_valid_o,
  input  logic                                  wr_ready_i,
  output logic [$clog2(N_COL)+ADDR_W-1:0]       wr_addr_o,
  output logic [DATA_W-1:0]                     wr_data_o,
  output logic                                  done_o,
  output logic [N_COL-1:0]                      overflow_o
);
  localparam int CW = $clog2(N_COL);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [N_COL-1:0] en_q, en_d, last_q, last_d, ovf_q, ovf_d;
  logic [N_COL-1:0][PW:0] wp_q, wp_d, rp_q, rp_d;
  logic [N_COL-1:0][FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [N_COL-1:0] empty, full, push, pop, acc;
  logic [CW-1:0] ptr_q, ptr_d, gnt;
  logic found, load, all_empty;
  logic [EW-1:0] head;
  logic [DATA_W-1:0] act;
  logic wr_valid_q, wr_valid_d;
  logic [CW+ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    gnt = ptr_q;
    found = 1'b0;
    for (int c = 0; c < N_COL; c++) begin
      empty[c] = wp_q[c] == rp_q[c];
      full[c] = (wp_q[c] - rp_q[c]) == (PW+1)'(FIFO_DEPTH);
    end
    for (int i = 1; i <= N_COL; i++)
      if (!found && !empty[CW'((int'(ptr_q) + i) % N_COL)]) begin
        gnt = CW'((int'(ptr_q) + i) % N_COL);
        found = 1'b1;
      end
  end
  // Load only when the output register is free or being consumed this cycle.
  assign load = found & (!wr_valid_q | wr_ready_i);
  assign head = mem_q[gnt][rp_q[gnt][PW-1:0]];
`ifdef RELU_EN
  assign act = head[DATA_W-1] ? '0 : head[DATA_W-1:0];
`else
  assign act = head[DATA_W-1:0];
`endif
  always_comb begin
    mem_d = mem_q;
    for (int c = 0; c < N_COL; c++) begin
      push[c] = conv_valid_i[c] & en_q[c] & (state_q == RUN);
      pop[c] = load & (gnt == CW'(c));
      // A full FIFO still accepts when its head leaves in the same cycle.
      acc[c] = push[c] & (!full[c] | pop[c]);
      wp_d[c] = start_i ? '0 : wp_q[c] + (PW+1)'(acc[c]);
      rp_d[c] = start_i ? '0 : rp_q[c] + (PW+1)'(pop[c]);
      if (acc[c]) mem_d[c][wp_q[c][PW-1:0]] = {addr_i[c], conv_result_i[c]};
    end
    en_d = start_i ? col_en_i : en_q;
    last_d = start_i ? '0 : last_q | (push & conv_last_i);
    ovf_d = start_i ? '0 : ovf_q | (push & full & ~pop);
    wr_valid_d = !start_i & (load | (wr_valid_q & !wr_ready_i));
    wr_addr_d = start_i ? '0 : load ? {gnt, head[EW-1:DATA_W]} : wr_addr_q;
    wr_data_d = start_i ? '0 : load ? act : wr_data_q;
    ptr_d = start_i ? CW'(N_COL-1) : load ? gnt : ptr_q;
    all_empty = wp_d == rp_d;
    // Next-cycle drain status lets done_o rise right after the final handshake.
    state_d = start_i ? RUN
            : (state_q == RUN && (last_q & en_q) == en_q) ? DRAIN
            : (state_q == DRAIN && all_empty && !wr_valid_d) ? DONE
            : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      en_q <= '0;
      last_q <= '0;
      ovf_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      mem_q <= '0;
      ptr_q <= CW'(N_COL-1);
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign done_o = state_q == DONE;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_relu_writeback_x16.sv
// tb_relu_writeback_x16: directed vectors with hand-computed expectations for relu_writeback_x16
module tb_relu_writeback_x16;
  localparam int N = 16, DW = 8, AW = 10;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  logic [N-1:0] en = '0, vld = '0, lst = '0;
  logic [N-1:0][DW-1:0] res = '0;
  logic [N-1:0][AW-1:0] adr = '0;
  logic wv, done;
  logic [AW+3:0] wa;
  logic [DW-1:0] wd;
  logic [N-1:0] ovf;
  int n_vec = 0, n_err = 0;
`ifdef RELU_EN
  localparam logic [DW-1:0] NEG3_EXP = 8'h00;
`else
  localparam logic [DW-1:0] NEG3_EXP = 8'hFD;
`endif
  relu_writeback_x16 dut (
    .clk(clk), .rst(rst), .start_i(start), .col_en_i(en),
    .conv_valid_i(vld), .conv_last_i(lst), .conv_result_i(res), .addr_i(adr),
    .wr_valid_o(wv), .wr_ready_i(ready), .wr_addr_o(wa), .wr_data_o(wd),
    .done_o(done), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int c, input logic [DW-1:0] r, input logic [AW-1:0] a, input logic l);
    vld[c] = 1'b1;
    res[c] = r;
    adr[c] = a;
    lst[c] = l;
  endtask
  task automatic clr;
    vld = '0;
    lst = '0;
  endtask
  task automatic do_start(input logic [N-1:0] e);
    en = e;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  function automatic logic [31:0] wr(input logic v, input logic [3:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return 32'({v, c, a, d});
  endfunction
  initial begin
    tick;
    chk("rst_wv", wv, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick;
    // single column
    do_start(16'h0001);
    drive(0, 8'd5, 10'd0, 1'b0);
    tick;
    chk("lat_nonempty_no_wv", wv, 0);
    drive(0, 8'hFD, 10'd1, 1'b0);
    tick;
    chk("single_w0", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 0, 8'd5));
    drive(0, 8'd127, 10'd2, 1'b1);
    tick;
    chk("single_w1_neg", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 1, NEG3_EXP));
    clr;
    tick;
    chk("single_w2", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 2, 8'd127));
    chk("single_done_early", done, 0);
    tick;
    chk("single_done", done, 1);
    chk("single_wv_idle", wv, 0);
    // empty layer: RUN, DRAIN, DONE on consecutive cycles
    do_start(16'h0000);
    chk("empty_run_done_fall", done, 0);
    tick;
    chk("empty_drain", done, 0);
    tick;
    chk("empty_done", done, 1);
    // all 16 columns fire together
    do_start(16'hFFFF);
    for (int c = 0; c < N; c++) drive(c, 8'(c), 10'd7, 1'b1);
    tick;
    clr;
    tick;
    for (int i = 0; i < N; i++) begin
      chk("all16_write", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 4'(i), 10'd7, 8'(i)));
      tick;
    end
    chk("all16_wv_end", wv, 0);
    chk("all16_done", done, 1);
    chk("all16_ovf", ovf, 0);
    // backpressure with overflow on column 3
    ready = 1'b0;
    do_start(16'h0009);
    drive(0, 8'd9, 10'd4, 1'b0);
    tick;
    clr;
    tick;
    chk("bp_pending", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 4, 8'd9));
    for (int k = 0; k < 10; k++) begin
      clr;
      if (k < 5) drive(3, 8'(k + 1), 10'(k), 1'b0);
      tick;
      chk("bp_stable", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 4, 8'd9));
    end
    clr;
    chk("bp_ovf", ovf, 32'h0008);
    ready = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 3, 10'(k), 8'(k + 1)));
      tick;
    end
    chk("bp_fifth_dropped", wv, 0);
    // abort with six entries queued and a pending write
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clr;
      drive(0, 8'(20 + k), 10'(k), 1'b0);
      if (k < 3) drive(3, 8'(30 + k), 10'(k), 1'b0);
      tick;
    end
    clr;
    chk("abort_pre", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 0, 8'd20));
    chk("abort_pre_ovf", ovf, 32'h0008);
    en = 16'h0009;
    start = 1'b1;
    drive(0, 8'd99, 10'd5, 1'b0);
    tick;
    start = 1'b0;
    clr;
    chk("abort_wv", wv, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("abort_flushed", wv, 0);
    end
    // reset in DRAIN
    ready = 1'b0;
    do_start(16'h0001);
    drive(0, 8'd50, 10'd9, 1'b1);
    tick;
    clr;
    tick;
    tick;
    chk("rstd_pre", wr(wv, wa[13:10], wa[9:0], wd), wr(1, 0, 9, 8'd50));
    #2 rst = 1'b1;
    #1;
    chk("rstd_wv", wv, 0);
    chk("rstd_wa", wa, 0);
    chk("rstd_wd", wd, 0);
    chk("rstd_done", done, 0);
    chk("rstd_ovf", ovf, 0);
    #1 rst = 1'b0;
    tick;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'(60 + k), 10'(k), 1'b1);
      tick;
      chk("idle_ignore_wv", wv, 0);
      chk("idle_ignore_done", done, 0);
    end
    clr;
    do_start(16'h0000);
    tick;
    tick;
    chk("post_rst_done", done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
